pcie_tx_arbiter: RTL and testbench

- Packet-atomic, round-robin arbiter merging NUM_CH AXI-Stream TLP sources onto the single 7-series PCIe core transmit stream (s_axis_tx_*).
- Sits between SoC-side TLP generators (config/memory requesters, completer, DMA) and the PCIe core.
- Gates new packets on core transmit-buffer availability (tx_buf_av) and link state.
- Counts core-reported TX drops.

---
 rtl/pcie_tx_pkg.sv | 47 ++++
 rtl/pcie_rr_pick.sv | 26 ++
 rtl/pcie_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_pcie_tx_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_tx_pkg.sv
// Shared types and helpers for the PCIe TX arbiter and the round-robin picker.
// The helpers work on MAX_CH-wide vectors so one function serves every channel count.
package pcie_tx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    localparam int TUSER_W     = 4;
    localparam int TX_BUF_AV_W = 6;
    localparam int MAX_CH      = 8;
    localparam int MAX_PTR_W   = 3;

    // First set bit of valid, scanning from ptr upward and wrapping at n.
    function automatic logic [MAX_CH-1:0] rr_pick(
        input logic [MAX_CH-1:0]    valid,
        input logic [MAX_PTR_W-1:0] ptr,
        input int unsigned          n
    );
        logic [MAX_CH-1:0]    oh;
        logic                 found;
        logic [MAX_PTR_W-1:0] idx;
        oh    = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_CH; k++) begin
            if (k < n && !found) begin
                idx = MAX_PTR_W'((32'(ptr) + k) % n);
                if (valid[idx]) begin
                    oh[idx] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
        return oh;
    endfunction

    function automatic logic [MAX_PTR_W-1:0] onehot_idx(input logic [MAX_CH-1:0] oh);
        logic [MAX_PTR_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < MAX_CH; k++) begin
            if (oh[MAX_PTR_W'(k)]) idx = MAX_PTR_W'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pcie_rr_pick.sv
// Combinational round-robin picker: one-hot grant plus its binary index.
// Generic in N so the RX demux can reuse it.
module pcie_rr_pick
    import pcie_tx_pkg::*;
#(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] idx_o
);

    logic [MAX_CH-1:0] valid_pad;
    logic [MAX_CH-1:0] pick_pad;

    always_comb begin
        valid_pad        = '0;
        valid_pad[N-1:0] = valid_i;
        pick_pad         = rr_pick(valid_pad, MAX_PTR_W'(ptr_i), N);
        grant_o          = pick_pad[N-1:0];
        idx_o            = PTR_W'(onehot_idx(pick_pad));
    end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Packet-atomic round-robin merge of NUM_CH TLP sources onto the 7-series PCIe TX stream.
// A grant is taken only in IDLE, so buffer/link checks never split a packet.
module pcie_tx_arbiter
    import pcie_tx_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 64,
    parameter int KEEP_W     = DATA_W / 8,
    parameter int BUF_AV_MIN = 2,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       lnk_up,
    input  logic [TX_BUF_AV_W-1:0]     tx_buf_av,
    input  logic                       tx_err_drop,
    input  logic [NUM_CH*DATA_W-1:0]   src_tdata,
    input  logic [NUM_CH*KEEP_W-1:0]   src_tkeep,
    input  logic [NUM_CH*TUSER_W-1:0]  src_tuser,
    input  logic [NUM_CH-1:0]          src_tlast,
    input  logic [NUM_CH-1:0]          src_tvalid,
    output logic [NUM_CH-1:0]          src_tready,
    output logic [DATA_W-1:0]          s_axis_tx_tdata,
    output logic [KEEP_W-1:0]          s_axis_tx_tkeep,
    output logic [TUSER_W-1:0]         s_axis_tx_tuser,
    output logic                       s_axis_tx_tlast,
    output logic                       s_axis_tx_tvalid,
    input  logic                       s_axis_tx_tready,
    output logic [NUM_CH-1:0]          grant,
    output logic                       busy,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [TX_BUF_AV_W-1:0] BUF_AV_MIN_L = TX_BUF_AV_W'(BUF_AV_MIN);

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]    gidx_q, gidx_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic [DATA_W-1:0]   data_arr [NUM_CH];
    logic [KEEP_W-1:0]   keep_arr [NUM_CH];
    logic [TUSER_W-1:0]  user_arr [NUM_CH];

    logic [NUM_CH-1:0]   pick_grant;
    logic [PTR_W-1:0]    pick_idx;
    logic                eligible;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign data_arr[gi]   = src_tdata[gi*DATA_W +: DATA_W];
            assign keep_arr[gi]   = src_tkeep[gi*KEEP_W +: KEEP_W];
            assign user_arr[gi]   = src_tuser[gi*TUSER_W +: TUSER_W];
            assign src_tready[gi] = (state_q == PKT) && (gidx_q == PTR_W'(gi)) && s_axis_tx_tready;
        end
    endgenerate

    pcie_rr_pick #(
        .N     (NUM_CH),
        .PTR_W (PTR_W)
    ) u_pick (
        .valid_i (src_tvalid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    assign eligible = (|src_tvalid) && lnk_up && (tx_buf_av >= BUF_AV_MIN_L);

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        gidx_d           = gidx_q;
        rr_ptr_d         = rr_ptr_q;
        s_axis_tx_tvalid = 1'b0;
        s_axis_tx_tdata  = '0;
        s_axis_tx_tkeep  = '0;
        s_axis_tx_tuser  = '0;
        s_axis_tx_tlast  = 1'b0;
        case (state_q)
            IDLE: begin
                if (eligible) begin
                    state_d = PKT;
                    grant_d = pick_grant;
                    gidx_d  = pick_idx;
                end
            end
            PKT: begin
                s_axis_tx_tvalid = src_tvalid[gidx_q];
                s_axis_tx_tdata  = data_arr[gidx_q];
                s_axis_tx_tkeep  = keep_arr[gidx_q];
                s_axis_tx_tuser  = user_arr[gidx_q];
                s_axis_tx_tlast  = src_tlast[gidx_q];
                if (s_axis_tx_tvalid && s_axis_tx_tready && s_axis_tx_tlast) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = (gidx_q == PTR_W'(NUM_CH - 1)) ? '0 : gidx_q + PTR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturates rather than wraps so a flood of drops stays visible.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (tx_err_drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = (state_q == PKT);
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Directed bench for pcie_tx_arbiter (NUM_CH=2, DATA_W=64, CNT_W=4).
// Expected values are hand-derived cycle by cycle.
module tb_pcie_tx_arbiter;

    logic         clk = 1'b0;
    logic         resetn;
    logic         lnk_up;
    logic [5:0]   tx_buf_av;
    logic         tx_err_drop;
    logic [127:0] src_tdata;
    logic [15:0]  src_tkeep;
    logic [7:0]   src_tuser;
    logic [1:0]   src_tlast;
    logic [1:0]   src_tvalid;
    logic [1:0]   src_tready;
    logic [63:0]  s_axis_tx_tdata;
    logic [7:0]   s_axis_tx_tkeep;
    logic [3:0]   s_axis_tx_tuser;
    logic         s_axis_tx_tlast;
    logic         s_axis_tx_tvalid;
    logic         s_axis_tx_tready;
    logic [1:0]   grant;
    logic         busy;
    logic [3:0]   drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pcie_tx_arbiter #(
        .NUM_CH     (2),
        .DATA_W     (64),
        .KEEP_W     (8),
        .BUF_AV_MIN (2),
        .CNT_W      (4)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .lnk_up           (lnk_up),
        .tx_buf_av        (tx_buf_av),
        .tx_err_drop      (tx_err_drop),
        .src_tdata        (src_tdata),
        .src_tkeep        (src_tkeep),
        .src_tuser        (src_tuser),
        .src_tlast        (src_tlast),
        .src_tvalid       (src_tvalid),
        .src_tready       (src_tready),
        .s_axis_tx_tdata  (s_axis_tx_tdata),
        .s_axis_tx_tkeep  (s_axis_tx_tkeep),
        .s_axis_tx_tuser  (s_axis_tx_tuser),
        .s_axis_tx_tlast  (s_axis_tx_tlast),
        .s_axis_tx_tvalid (s_axis_tx_tvalid),
        .s_axis_tx_tready (s_axis_tx_tready),
        .grant            (grant),
        .busy             (busy),
        .drop_cnt         (drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s = %0h t=%0t", tag, obs, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic v, input logic [63:0] d, input logic l);
        src_tvalid[i]        = v;
        src_tdata[i*64 +: 64] = d;
        src_tlast[i]         = l;
        src_tkeep[i*8 +: 8]   = (i == 0) ? 8'hFF : 8'h0F;
        src_tuser[i*4 +: 4]   = 4'(i + 1);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".grant"}, 64'(grant), 64'h0);
        chk({tag, ".busy"}, 64'(busy), 64'h0);
        chk({tag, ".tvalid"}, 64'(s_axis_tx_tvalid), 64'h0);
        chk({tag, ".src_tready"}, 64'(src_tready), 64'h0);
    endtask

    initial begin
        resetn = 1'b0; lnk_up = 1'b1; tx_buf_av = 6'd10; tx_err_drop = 1'b0;
        src_tdata = '0; src_tkeep = '0; src_tuser = '0; src_tlast = '0; src_tvalid = '0;
        s_axis_tx_tready = 1'b1;
        #3;
        chk_idle_outputs("reset");
        chk("reset.drop_cnt", 64'(drop_cnt), 64'h0);
        tick();
        resetn = 1'b1;

        // Single channel, 3-beat packet
        set_ch(0, 1'b1, 64'hA0, 1'b0);
        chk("t1.idle_tvalid", 64'(s_axis_tx_tvalid), 64'h0);
        chk("t1.idle_tready", 64'(src_tready), 64'h0);
        tick();
        chk("t1.grant", 64'(grant), 64'h1);
        chk("t1.busy", 64'(busy), 64'h1);
        chk("t1.tvalid", 64'(s_axis_tx_tvalid), 64'h1);
        chk("t1.beat0", s_axis_tx_tdata, 64'hA0);
        chk("t1.tuser", 64'(s_axis_tx_tuser), 64'h1);
        chk("t1.src_tready", 64'(src_tready), 64'h1);
        tick();
        set_ch(0, 1'b1, 64'hA1, 1'b0);
        chk("t1.beat1", s_axis_tx_tdata, 64'hA1);
        chk("t1.beat1_last", 64'(s_axis_tx_tlast), 64'h0);
        tick();
        set_ch(0, 1'b1, 64'hA2, 1'b1);
        chk("t1.beat2", s_axis_tx_tdata, 64'hA2);
        chk("t1.beat2_last", 64'(s_axis_tx_tlast), 64'h1);
        tick();
        set_ch(0, 1'b0, 64'h0, 1'b0);
        chk_idle_outputs("t1.end");

        // Contention from reset: ch0, bubble, ch1, bubble, ch0
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        set_ch(0, 1'b1, 64'hB00, 1'b0);
        set_ch(1, 1'b1, 64'hC10, 1'b0);
        chk("t2.idle_grant", 64'(grant), 64'h0);
        tick();
        chk("t2.grant_ch0", 64'(grant), 64'h1);
        chk("t2.b00", s_axis_tx_tdata, 64'hB00);
        chk("t2.src_tready0", 64'(src_tready), 64'h1);
        tick();
        set_ch(0, 1'b1, 64'hB01, 1'b1);
        chk("t2.b01", s_axis_tx_tdata, 64'hB01);
        tick();
        set_ch(0, 1'b1, 64'hB10, 1'b1);
        chk("t2.bubble_grant", 64'(grant), 64'h0);
        chk("t2.bubble_tvalid", 64'(s_axis_tx_tvalid), 64'h0);
        tick();
        chk("t2.grant_ch1", 64'(grant), 64'h2);
        chk("t2.c10", s_axis_tx_tdata, 64'hC10);
        chk("t2.src_tready1", 64'(src_tready), 64'h2);
        tick();
        set_ch(1, 1'b1, 64'hC11, 1'b1);
        chk("t2.c11", s_axis_tx_tdata, 64'hC11);
        tick();
        set_ch(1, 1'b0, 64'h0, 1'b0);
        chk("t2.bubble2_grant", 64'(grant), 64'h0);
        tick();
        chk("t2.round2_ch0", 64'(grant), 64'h1);
        chk("t2.b10", s_axis_tx_tdata, 64'hB10);
        tick();
        set_ch(0, 1'b0, 64'h0, 1'b0);
        chk("t2.end_grant", 64'(grant), 64'h0);

        // Buffer gating on ch1
        tx_buf_av = 6'd1;
        set_ch(1, 1'b1, 64'hD0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("t3.gated%0d", c), 64'(grant), 64'h0);
        end
        tx_buf_av = 6'd2;
        set_ch(0, 1'b1, 64'hF0, 1'b0);
        tick();
        chk("t3.grant_ch1", 64'(grant), 64'h2);

        // Backpressure with ch0 waiting
        s_axis_tx_tready = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t4.bp_tready%0d", c), 64'(src_tready), 64'h0);
            chk($sformatf("t4.bp_grant%0d", c), 64'(grant), 64'h2);
            chk($sformatf("t4.bp_tvalid%0d", c), 64'(s_axis_tx_tvalid), 64'h1);
            tick();
        end
        chk("t4.tkeep", 64'(s_axis_tx_tkeep), 64'h0F);
        chk("t4.tuser", 64'(s_axis_tx_tuser), 64'h2);
        chk("t4.d0", s_axis_tx_tdata, 64'hD0);
        s_axis_tx_tready = 1'b1;
        #1;
        chk("t4.src_tready1", 64'(src_tready), 64'h2);
        tick();
        set_ch(1, 1'b1, 64'hD1, 1'b1);
        chk("t4.d1", s_axis_tx_tdata, 64'hD1);
        chk("t4.grant_hold", 64'(grant), 64'h2);
        tick();
        set_ch(1, 1'b0, 64'h0, 1'b0);
        set_ch(0, 1'b0, 64'h0, 1'b0);
        chk("t4.end_grant", 64'(grant), 64'h0);
        tick();

        // Link drop mid-packet: ch0 4 beats
        set_ch(0, 1'b1, 64'hE0, 1'b0);
        tick();
        chk("t5.grant", 64'(grant), 64'h1);
        chk("t5.e0", s_axis_tx_tdata, 64'hE0);
        tick();
        set_ch(0, 1'b1, 64'hE1, 1'b0);
        lnk_up = 1'b0;
        #1;
        chk("t5.e1_tvalid", 64'(s_axis_tx_tvalid), 64'h1);
        chk("t5.e1", s_axis_tx_tdata, 64'hE1);
        tick();
        set_ch(0, 1'b1, 64'hE2, 1'b0);
        chk("t5.e2", s_axis_tx_tdata, 64'hE2);
        tick();
        set_ch(0, 1'b1, 64'hE3, 1'b1);
        chk("t5.e3", s_axis_tx_tdata, 64'hE3);
        chk("t5.e3_last", 64'(s_axis_tx_tlast), 64'h1);
        tick();
        set_ch(0, 1'b1, 64'hE4, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t5.nolink%0d", c), 64'(grant), 64'h0);
            tick();
        end
        set_ch(0, 1'b0, 64'h0, 1'b0);
        lnk_up = 1'b1;

        // Drop counter saturation
        tx_err_drop = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        chk("t6.drop3", 64'(drop_cnt), 64'h3);
        for (int c = 0; c < 17; c++) tick();
        chk("t6.drop_sat", 64'(drop_cnt), 64'hF);
        tx_err_drop = 1'b0;
        tick();
        chk("t6.drop_hold", 64'(drop_cnt), 64'hF);

        // Async reset mid-packet
        set_ch(0, 1'b1, 64'h70, 1'b0);
        tick();
        chk("t7.busy", 64'(busy), 64'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk_idle_outputs("t7.rst");
        chk("t7.drop_cnt", 64'(drop_cnt), 64'h0);
        tick();
        resetn = 1'b1;
        tick();
        chk("t7.restart_grant", 64'(grant), 64'h1);
        chk("t7.restart_data", s_axis_tx_tdata, 64'h70);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
